usb_tx_line_encoder: RTL and testbench



---
 rtl/usb_tx_line_encoder_pkg.sv | 27 ++
 rtl/usb_tx_line_encoder_if.sv | 25 ++
 rtl/usb_tx_line_encoder_bit_timer.sv | 42 ++++
 rtl/usb_tx_line_encoder.sv | 152 +++++++++++++++
 tb/tb_usb_tx_line_encoder.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/usb_tx_line_encoder_pkg.sv
`default_nettype none
// ============================================================================
// usb_tx_pkg : shared types and line-state constants for the USB TX encoder
// Revision   : 1.0
// ============================================================================
package usb_tx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    EOP_SE0 = 2'd2,
    EOP_J   = 2'd3
  } state_t;

  // Line states encoded as {dp, dm}
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  localparam int DEFAULT_CLKS_PER_BIT = 4;

  function automatic logic [1:0] nrzi_toggle(input logic [1:0] line);
    return (line == J) ? K : J;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_tx_line_encoder_if.sv
`default_nettype none
// ============================================================================
// usb_tx_line_encoder_if : shifter/controller side and line side of the encoder
// Revision               : 1.0
// ============================================================================
interface usb_tx_line_encoder_if;
  logic tx_en;
  logic serial_in;
  logic shift_strobe;
  logic byte_done;
  logic tx_busy;
  logic dp;
  logic dm;

  modport master (
    output tx_en, serial_in,
    input  shift_strobe, byte_done, tx_busy, dp, dm
  );

  modport slave (
    input  tx_en, serial_in,
    output shift_strobe, byte_done, tx_busy, dp, dm
  );
endinterface
`default_nettype wire

// File: rtl/usb_tx_line_encoder_bit_timer.sv
`default_nettype none
// ============================================================================
// usb_tx_bit_timer : modulo-CLKS_PER_BIT counter with bit-period phase pulses
// Revision         : 1.0
// ============================================================================
module usb_tx_bit_timer
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_period_start,
  output logic o_pre_end,
  output logic o_period_end
);

  localparam int              CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   C_PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  // pre_end lets the parent register a pulse that lands on the last cycle
  assign o_period_start = (r_cnt == '0);
  assign o_pre_end      = (r_cnt == C_PRE);
  assign o_period_end   = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/usb_tx_line_encoder.sv
`default_nettype none
// ============================================================================
// usb_tx_line_encoder : FS USB TX bit stuffer, NRZI encoder and EOP generator
// Revision            : 1.0
// ============================================================================
module usb_tx_line_encoder
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STUFF_LIMIT  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  usb_tx_line_encoder_if.slave  bus
);

  localparam logic [2:0] C_STUFF_LIMIT = 3'(STUFF_LIMIT);

  state_t     r_state;
  logic [1:0] r_line;
  logic [2:0] r_ones;
  logic [2:0] r_bit_idx;
  logic       r_last;
  logic       r_data_period;
  logic       r_eop_half;
  logic       r_busy;
  logic       r_shift_strobe;
  logic       r_byte_done;

  logic w_period_start;
  logic w_pre_end;
  logic w_period_end;
  logic w_timer_en;
  logic w_timer_clr;
  logic w_bit_start;
  logic w_stuff;
  logic w_to_eop;
  logic w_next_data;
  logic w_cur_data;

  // The timer idles at 0 so the IDLE cycle that sees tx_en acts as the
  // first bit's period-start cycle.
  assign w_timer_en  = (r_state != IDLE) || bus.tx_en;
  assign w_timer_clr = ((r_state == IDLE) && !bus.tx_en) ||
                       ((r_state == EOP_J) && w_period_start);

  usb_tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk            (clk),
    .rst            (rst),
    .i_en           (w_timer_en),
    .i_clr          (w_timer_clr),
    .o_period_start (w_period_start),
    .o_pre_end      (w_pre_end),
    .o_period_end   (w_period_end)
  );

  always_comb begin
    w_bit_start = w_period_start &&
                  (((r_state == IDLE) && bus.tx_en) || (r_state == DATA));
    w_stuff     = w_bit_start && (r_state == DATA) && (r_ones == C_STUFF_LIMIT);
    w_to_eop    = w_bit_start && (r_state == DATA) && !w_stuff && r_last;
    w_next_data = w_bit_start && !w_stuff && !w_to_eop;
    // With CLKS_PER_BIT=2 the strobe decision coincides with the period start
    w_cur_data  = w_bit_start ? w_next_data : r_data_period;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_line         <= J;
      r_ones         <= 3'd0;
      r_bit_idx      <= 3'd0;
      r_last         <= 1'b0;
      r_data_period  <= 1'b0;
      r_eop_half     <= 1'b0;
      r_busy         <= 1'b0;
      r_shift_strobe <= 1'b0;
      r_byte_done    <= 1'b0;
    end else begin
      r_shift_strobe <= w_pre_end && w_cur_data;
      r_byte_done    <= w_pre_end && w_cur_data && (r_bit_idx == 3'd7);

      if (w_period_end && r_shift_strobe) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (r_byte_done) begin
        r_last <= !bus.tx_en;
      end
      if (w_bit_start) begin
        r_data_period <= w_next_data;
      end

      case (r_state)
        IDLE: begin
          r_ones    <= 3'd0;
          r_bit_idx <= 3'd0;
          r_last    <= 1'b0;
          if (bus.tx_en) begin
            r_state <= DATA;
            r_busy  <= 1'b1;
            r_line  <= bus.serial_in ? J : K;
            r_ones  <= bus.serial_in ? 3'd1 : 3'd0;
          end
        end
        DATA: begin
          if (w_stuff) begin
            r_line <= nrzi_toggle(r_line);
            r_ones <= 3'd0;
          end else if (w_to_eop) begin
            r_state    <= EOP_SE0;
            r_line     <= SE0;
            r_eop_half <= 1'b0;
          end else if (w_bit_start) begin
            if (!bus.serial_in) begin
              r_line <= nrzi_toggle(r_line);
              r_ones <= 3'd0;
            end else if (r_ones != C_STUFF_LIMIT) begin
              r_ones <= r_ones + 3'd1;
            end
          end
        end
        EOP_SE0: begin
          if (w_period_start) begin
            if (r_eop_half) begin
              r_state <= EOP_J;
              r_line  <= J;
            end else begin
              r_eop_half <= 1'b1;
            end
          end
        end
        EOP_J: begin
          if (w_period_start) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.dp           = r_line[1];
  assign bus.dm           = r_line[0];
  assign bus.tx_busy      = r_busy;
  assign bus.shift_strobe = r_shift_strobe;
  assign bus.byte_done    = r_byte_done;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_line_encoder.sv
`default_nettype none
// ============================================================================
// tb_usb_tx_line_encoder : directed bench with a shifter model and packet traces
// Revision               : 1.0
// ============================================================================
module tb_usb_tx_line_encoder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  usb_tx_line_encoder_if bus ();

  usb_tx_line_encoder #(
    .CLKS_PER_BIT (4),
    .STUFF_LIMIT  (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [1:0] tr_line [0:399];
  logic       tr_stb  [0:399];
  logic       tr_bd   [0:399];
  int         ncyc;
  logic       done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drives one packet while modelling the shifter (load beats shift) and
  // dropping tx_en once drop_at strobes have been seen.
  task automatic run_pkt(input logic [7:0] b0, input logic [7:0] b1,
                         input int nbytes, input int drop_at);
    logic [7:0] sh;
    int nstb;
    int nload;
    ncyc = 0;
    done = 1'b0;
    @(negedge clk);
    sh    = b0;
    nload = 1;
    nstb  = 0;
    bus.serial_in = sh[0];
    bus.tx_en     = 1'b1;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      tr_line[c] = {bus.dp, bus.dm};
      tr_stb[c]  = bus.shift_strobe;
      tr_bd[c]   = bus.byte_done;
      if (!bus.tx_busy) begin
        done = 1'b1;
        ncyc = c;
      end else begin
        if (bus.shift_strobe) nstb++;
        if (bus.byte_done) begin
          if (nload < nbytes) begin
            sh = b1;
            nload++;
          end
        end else if (bus.shift_strobe) begin
          sh = sh >> 1;
        end
        bus.serial_in = sh[0];
        if (nstb >= drop_at) bus.tx_en = 1'b0;
      end
    end
    bus.tx_en = 1'b0;
  endtask

  task automatic check_pkt(input string nm, input int P, input logic [63:0] exp_dp,
                           input logic [63:0] exp_stb, input int nbytes,
                           input int exp_bd_first, input int exp_bd_last);
    logic [63:0] got_dp, got_dm, got_stb, mask;
    int nstb, nbd, bd_first, bd_last, nse0, se0_first, last_idx;
    got_dp = '0; got_dm = '0; got_stb = '0;
    mask = (64'd1 << P) - 64'd1;
    for (int k = 0; k < P; k++) begin
      got_dp[k]  = tr_line[4*k][1];
      got_dm[k]  = tr_line[4*k][0];
      got_stb[k] = tr_stb[4*k+2];
    end
    nstb = 0; nbd = 0; bd_first = -1; bd_last = -1; nse0 = 0; se0_first = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (tr_stb[c] === 1'b1) nstb++;
      if (tr_bd[c] === 1'b1) begin
        nbd++;
        if (bd_first < 0) bd_first = c;
        bd_last = c;
      end
      if (tr_line[c] === 2'b00) begin
        nse0++;
        if (se0_first < 0) se0_first = c;
      end
    end
    last_idx = (ncyc > 0) ? ncyc - 1 : 0;
    chk($sformatf("%s_finished", nm), 64'(done), 64'd1);
    chk($sformatf("%s_dp_periods", nm), got_dp, exp_dp);
    chk($sformatf("%s_dm_periods", nm), got_dm, ~exp_dp & mask);
    chk($sformatf("%s_strobe_periods", nm), got_stb, exp_stb);
    chk($sformatf("%s_strobe_count", nm), 64'(nstb), 64'(8 * nbytes));
    chk($sformatf("%s_byte_done_count", nm), 64'(nbd), 64'(nbytes));
    chk($sformatf("%s_byte_done_first", nm), 64'(bd_first), 64'(exp_bd_first));
    chk($sformatf("%s_byte_done_last", nm), 64'(bd_last), 64'(exp_bd_last));
    chk($sformatf("%s_se0_start", nm), 64'(se0_first), 64'(4 * P));
    chk($sformatf("%s_se0_length", nm), 64'(nse0), 64'd8);
    chk($sformatf("%s_busy_length", nm), 64'(ncyc), 64'(4 * P + 12));
    chk($sformatf("%s_eop_j", nm), 64'(tr_line[last_idx]), 64'(2'b10));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nstb_rst;
    rst           = 1'b1;
    bus.tx_en     = 1'b0;
    bus.serial_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_line", 64'({bus.dp, bus.dm}), 64'(2'b10));
    chk("reset_busy", 64'(bus.tx_busy), 64'd0);
    chk("reset_strobe", 64'({bus.shift_strobe, bus.byte_done}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 0x00: alternating K/J, tx_en dropped at the load
    run_pkt(8'h00, 8'h00, 1, 8);
    check_pkt("byte00", 8, 64'b10101010, 64'hFF, 1, 30, 30);

    // 0xFF: six held J, stuffed K, two held K
    run_pkt(8'hFF, 8'h00, 1, 8);
    check_pkt("byteFF", 9, 64'b000111111, 64'b110111111, 1, 34, 34);

    // Wire bits 0,0,1,1,1,1,1,1: stuff bit trails the last data bit
    run_pkt(8'hFC, 8'h00, 1, 8);
    check_pkt("tail_stuff", 9, 64'b011111110, 64'b011111111, 1, 30, 30);

    // Two 0xFF bytes back to back: ones count carries over the boundary
    run_pkt(8'hFF, 8'hFF, 2, 16);
    check_pkt("two_FF", 18, 64'b11111_0000000_111111, 64'b1111_0_111111_0_111111, 2, 34, 70);

    // 0x55 with tx_en dropped after the 3rd strobe: full byte still sent
    run_pkt(8'h55, 8'h00, 1, 3);
    check_pkt("early_drop", 8, 64'b10011001, 64'hFF, 1, 30, 30);

    // Asynchronous reset in the middle of DATA
    @(negedge clk);
    bus.serial_in = 1'b0;
    bus.tx_en     = 1'b1;
    repeat (10) @(negedge clk);
    chk("midpkt_busy", 64'(bus.tx_busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_line", 64'({bus.dp, bus.dm}), 64'(2'b10));
    chk("async_rst_busy", 64'(bus.tx_busy), 64'd0);
    bus.tx_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    nstb_rst = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.shift_strobe !== 1'b0 || bus.byte_done !== 1'b0) nstb_rst++;
    end
    chk("post_rst_no_strobe", 64'(nstb_rst), 64'd0);
    chk("post_rst_line", 64'({bus.dp, bus.dm, bus.tx_busy}), 64'(3'b100));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
